// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the RV32I pipeline registers.
//   XLEN_DEFAULT : default datapath width
//   NOP_INSTR    : canonical bubble instruction (addi x0, x0, 0)
//   ctrl_t       : 10-bit decoded control bundle carried from ID to EX
package riscv_pipe_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic       MemWrite;
    logic       Jump;
    logic       Branch;
    logic [2:0] ALUControl;
    logic       ALUSrc;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with synchronous reset, clear and enable.
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset, loads RST_VAL
//   i_en    : load i_d when high, otherwise hold
//   i_clr   : load CLR_VAL (bubble); overrides i_en
//   i_d     : next-stage data
//   o_q     : registered data
module pipe_stage_reg #(
  parameter int unsigned   W       = 32,
  parameter logic [W-1:0]  RST_VAL = '0,
  parameter logic [W-1:0]  CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= RST_VAL;
    end else if (i_clr) begin
      r_q <= CLR_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/hazard_pipe_regs.sv
// PC, IF/ID and ID/EX registers of the 5-stage RV32I core, driven by the
// hazard unit's stall/flush outputs, plus saturating hazard counters.
//   clk, reset                 : clock and synchronous active-high reset
//   StallF/StallD              : hold PC / hold IF/ID
//   FlushD/FlushE              : bubble IF/ID / bubble ID/EX
//   PCSrcE, PCTargetE          : taken branch/jump redirect from EX
//   InstrF                     : instruction fetched at PCF
//   PCF                        : fetch address
//   InstrD, PCD, PCPlus4D, ValidD : IF/ID contents
//   CtrlD, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD : decode-stage inputs
//   CtrlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE : ID/EX
//   ResultSrcE0                : load-in-EX flag for hazard detection
//   StallCnt, FlushCnt, BubbleCnt : saturating performance counters
module hazard_pipe_regs
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             FlushE,
  input  logic             PCSrcE,
  input  logic [XLEN-1:0]  PCTargetE,
  input  logic [31:0]      InstrF,
  output logic [XLEN-1:0]  PCF,
  output logic [31:0]      InstrD,
  output logic [XLEN-1:0]  PCD,
  output logic [XLEN-1:0]  PCPlus4D,
  output logic             ValidD,
  input  ctrl_t            CtrlD,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  output ctrl_t            CtrlE,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             ResultSrcE0,
  output logic             ValidE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] BubbleCnt
);

  localparam int unsigned IFID_W = 1 + 32 + 2 * XLEN;
  localparam int unsigned IDEX_W = 1 + CTRL_W + 5 * XLEN + 15;

  // Reset and flush leave the same bubble in IF/ID: {valid, instr, pc, pc+4}.
  localparam logic [IFID_W-1:0] IFID_BUBBLE = {1'b0, NOP_INSTR, {(2 * XLEN){1'b0}}};

  // PC register
  logic [XLEN-1:0] r_pcf;
  logic [XLEN-1:0] w_pcf_plus4;

  assign w_pcf_plus4 = r_pcf + XLEN'(4);

  // Redirect outranks stall so a taken branch is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcf <= RESET_PC;
    end else if (PCSrcE) begin
      r_pcf <= PCTargetE;
    end else if (!StallF) begin
      r_pcf <= w_pcf_plus4;
    end
  end

  assign PCF = r_pcf;

  // IF/ID register
  logic [IFID_W-1:0] w_ifid_d;
  logic [IFID_W-1:0] w_ifid_q;

  assign w_ifid_d = {1'b1, InstrF, r_pcf, w_pcf_plus4};

  pipe_stage_reg #(
    .W       (IFID_W),
    .RST_VAL (IFID_BUBBLE),
    .CLR_VAL (IFID_BUBBLE)
  ) u_if_id (
    .clk   (clk),
    .reset (reset),
    .i_en  (~StallD),
    .i_clr (FlushD),
    .i_d   (w_ifid_d),
    .o_q   (w_ifid_q)
  );

  assign {ValidD, InstrD, PCD, PCPlus4D} = w_ifid_q;

  // ID/EX register: no EX stall, so it loads every cycle unless bubbled.
  logic [IDEX_W-1:0] w_idex_d;
  logic [IDEX_W-1:0] w_idex_q;

  assign w_idex_d = {1'b1, CtrlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD};

  pipe_stage_reg #(
    .W       (IDEX_W),
    .RST_VAL ('0),
    .CLR_VAL ('0)
  ) u_id_ex (
    .clk   (clk),
    .reset (reset),
    .i_en  (1'b1),
    .i_clr (FlushE),
    .i_d   (w_idex_d),
    .o_q   (w_idex_q)
  );

  assign {ValidE, CtrlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE} = w_idex_q;

  assign ResultSrcE0 = CtrlE.ResultSrc[0];

  // Saturating hazard counters
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (StallF && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (FlushD && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
      if (FlushE && !(&r_bubble_cnt)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end

  assign StallCnt  = r_stall_cnt;
  assign FlushCnt  = r_flush_cnt;
  assign BubbleCnt = r_bubble_cnt;

endmodule

// File: doc/hazard_pipe_regs.md
Name: hazard_pipe_regs

Overview:
- Pipeline-register block that consumes the hazard unit's stall and flush outputs.
- Holds the PC register (IF), the IF/ID register and the ID/EX register of the 5-stage RV32I core.
- Applies stall, flush and branch redirect with fixed priority.
- Feeds RdE and ResultSrcE0 back to hazard detection, and keeps saturating stall/flush/bubble counters for the UVM scoreboard.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, PCF value while reset is asserted.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- StallF  in  1  hold PCF.
- StallD  in  1  hold IF/ID register.
- FlushD  in  1  clear IF/ID register to bubble.
- FlushE  in  1  clear ID/EX register to bubble.
- PCSrcE  in  1  branch/jump taken in EX.
- PCTargetE  in  XLEN  redirect target.
- InstrF  in  32  instruction read combinationally at PCF.
- PCF  out  XLEN  fetch address.
- InstrD, PCD, PCPlus4D  out  32/XLEN/XLEN  IF/ID contents.
- ValidD  out  1  IF/ID holds a real instruction.
- CtrlD  in  ctrl_t  decoded control bundle.
- RD1D, RD2D, ImmExtD  in  XLEN  register-file reads and immediate.
- Rs1D, Rs2D, RdD  in  5  register indices.
- CtrlE  out  ctrl_t  registered control bundle.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  XLEN  ID/EX data.
- Rs1E, Rs2E, RdE  out  5  ID/EX register indices.
- ResultSrcE0  out  1  CtrlE.ResultSrc[0], load-in-EX flag.
- ValidE  out  1  ID/EX holds a real instruction.
- StallCnt, FlushCnt, BubbleCnt  out  CNT_W  performance counters.

Behaviour:
- Reset (synchronous, highest priority):
  - PCF=RESET_PC, InstrD=NOP_INSTR (32'h0000_0013), all other D/E data 0.
  - CtrlE='0, ValidD=ValidE=0, all counters 0.
  - Reset asserted mid-operation discards all in-flight state on that edge.
- PC register, priority order:
  - reset.
  - else PCSrcE: PCF<=PCTargetE. PCSrcE overrides StallF; load-use and taken branch cannot legally coincide, but PCSrcE still wins if they do.
  - else StallF: hold.
  - else PCF<=PCF+4, modulo 2^XLEN (wraps 32'hFFFF_FFFC -> 0).
- IF/ID register, priority order:
  - reset.
  - FlushD: InstrD=NOP_INSTR, PCD=PCPlus4D=0, ValidD=0. FlushD beats StallD.
  - StallD: hold all fields.
  - else: InstrD<=InstrF, PCD<=PCF, PCPlus4D<=PCF+4, ValidD<=1.
- ID/EX register, priority order:
  - reset.
  - FlushE: CtrlE='0, RdE=Rs1E=Rs2E=0, data 0, ValidE=0 (bubble, no RegWrite/MemWrite).
  - else: load all D-side inputs, ValidE<=1. There is no EX stall.
- Latency: one cycle per register. First ValidD=1 appears one edge after reset deasserts.
- Simultaneous StallD & FlushE (load-use): IF/ID holds and ID/EX bubbles on the same edge, so the dependent instruction re-decodes next cycle.
- Counters:
  - StallCnt++ on each cycle with StallF.
  - FlushCnt++ on each cycle with FlushD.
  - BubbleCnt++ on each cycle with FlushE.
  - Increment only when reset is low; saturate at 2^CNT_W-1, never wrap.
- ResultSrcE0 is purely combinational from CtrlE.

Decomposition:
- Package riscv_pipe_pkg:
  - XLEN default.
  - NOP_INSTR.
  - ctrl_t packed struct: RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc = 10 bits.
- Sub-module pipe_stage_reg:
  - Parameterised width W, reset value and clear value.
  - Inputs en and clr, with clr over en.
  - Instantiated once for IF/ID and once for ID/EX.
- PC register and counters stay in the top module.

Test Plan:
- Reset release with InstrF=32'h00500093, no hazards -> cycle 1: InstrD=32'h00500093, PCD=0, ValidD=1. Cycle 2: PCF=8, ValidE=1, RdE=1.
- StallF=StallD=FlushE=1 for one cycle at PCF=0x10 -> PCF stays 0x10 and InstrD held. Next edge: CtrlE=0, ValidE=0, StallCnt=1, BubbleCnt=1.
- PCSrcE=1, PCTargetE=0x40, FlushD=FlushE=1 -> PCF=0x40, InstrD=0x00000013, ValidD=0, ValidE=0, FlushCnt=1.
- PCSrcE=1 and StallF=1 together, PCTargetE=0x80 -> PCF=0x80 (redirect wins). StallD=1 with FlushD=1 -> ValidD=0.
- Pre-load StallCnt to 2^CNT_W-2 (via CNT_W=4 build, 14 stall cycles), then 3 more stall cycles -> StallCnt reads 15 and stays 15.
- Reset asserted mid-stream with ValidD=ValidE=1 and counters nonzero -> next edge: all outputs at reset values. PCF=0 at PCF=32'hFFFF_FFFC with no stall -> wraps to 0.
